program_counter_rs: RTL and testbench
=====================================

// Module: program_counter_rs
// PURPOSE
//  Parametrised program counter with an integrated return-address stack (RAS).
//  - Sits between control unit and instruction memory. Holds the current fetch address.
//  - Supports increment, absolute load, relative branch, call and return.
//  - Drives the address onto the shared data bus / data-address bus through tri-states.
// PARAMETERS
//  WIDTH      16  address/data bus width in bits
//  DEPTH      8   RAS entries (power of two, >=2)
//  RESET_VEC  16  i_addr value after reset
// PORTS
//  clk        in     1      rising-edge clock
//  rst        in     1      synchronous active-high reset
//  increment  in     1      i_addr <= i_addr+1
//  load       in     1      i_addr <= d_bus
//  branch     in     1      i_addr <= i_addr + d_bus (two's complement offset)
//  call       in     1      push i_addr+1 to RAS; i_addr <= d_bus
//  ret        in     1      pop RAS top into i_addr
//  push       in     1      drive i_addr onto d_addr, else Z
//  push_d     in     1      drive i_addr onto d_bus, else Z
//  d_bus      inout  WIDTH  shared data bus
//  d_addr     out    WIDTH  data address bus (tri-state)
//  i_addr     out    WIDTH  instruction fetch address (registered)
//  rs_empty   out    1      RAS holds 0 entries
//  rs_full    out    1      RAS holds DEPTH entries
//  rs_ovf     out    1      sticky: call issued while full
//  rs_unf     out    1      sticky: ret issued while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): i_addr=RESET_VEC, count=0, rs_empty=1, rs_full=0,
//    rs_ovf=0, rs_unf=0. RAS storage is not cleared.
//    rst overrides every other input in that cycle, including mid-call/ret.
//  - Command priority, one action per cycle: call > ret > load > branch > increment.
//    No command asserted: i_addr holds.
//  - All updates take effect at the posedge where the command is sampled.
//    i_addr is visible the next cycle (latency 1).
//  - Arithmetic is modulo 2^WIDTH; i_addr+1 wraps 2^WIDTH-1 -> 0.
//  - branch adds d_bus as a signed WIDTH-bit offset.
//  - call:
//    - Writes i_addr+1 (wrapped) at the top-of-stack pointer and advances the pointer.
//    - count = min(count+1, DEPTH).
//    - When already full, the oldest entry is overwritten (circular) and rs_ovf is set.
//    - i_addr <= d_bus regardless.
//  - ret:
//    - Not empty: i_addr <= top entry, pointer retreats, count-1.
//    - Empty: i_addr holds, rs_unf set, pointer and count unchanged.
//  - call and ret in the same cycle: call wins, ret ignored, no flag.
//  - rs_full/rs_empty are registered, derived from count, and update with count.
//  - Sticky flags clear only on rst.
//  - Tri-states are combinational: d_addr = push ? i_addr : Z; d_bus = push_d ? i_addr : Z.
//    The current (pre-update) i_addr is driven.
//  - push_d together with load/branch/call is a protocol violation. The module still
//    samples d_bus, which equals i_addr (load: hold; branch: i_addr doubles).
//    The bench flags it with an assertion.
// TESTING
//  1. Reset, then 3 cycles of increment -> i_addr 16,17,18,19; rs_empty=1.
//  2. i_addr=0x0010, call with d_bus=0x0200 -> i_addr=0x0200, count=1.
//     Then ret -> i_addr=0x0011, rs_empty=1.
//  3. DEPTH=8: 9 nested calls -> rs_full=1 and rs_ovf=1 after the 9th.
//     8 rets return the last 8 addresses in LIFO order.
//     The 9th ret sets rs_unf with i_addr unchanged.
//  4. i_addr=0x0005, branch with d_bus=0xFFFE -> 0x0003.
//     i_addr=0xFFFF, increment -> 0x0000.
//  5. call+ret+increment in the same cycle -> only the call executes.
//     rst asserted during a ret -> i_addr=16, count=0, flags clear.
//  6. push=1 -> d_addr==i_addr; push=0 -> d_addr Z.
//     push_d=1 -> d_bus==i_addr; push_d=0 -> d_bus Z.

Source files
------------

// File: rtl/program_counter_rs.sv
// Program counter with a circular return-address stack and tri-state bus drivers.
// One command per cycle (call > ret > load > branch > increment), registered i_addr.
module program_counter_rs #(
    parameter int              WIDTH     = 16,
    parameter int              DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(16)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             increment,
    input  logic             load,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic             push,
    input  logic             push_d,
    inout  wire  [WIDTH-1:0] d_bus,
    output logic [WIDTH-1:0] d_addr,
    output logic [WIDTH-1:0] i_addr,
    output logic             rs_empty,
    output logic             rs_full,
    output logic             rs_ovf,
    output logic             rs_unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    ptr, ptr_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] addr_next, ret_addr;
    logic             ovf_next, unf_next;

    // Drivers expose the current (pre-update) fetch address.
    assign d_addr = push   ? i_addr : {WIDTH{1'bz}};
    assign d_bus  = push_d ? i_addr : {WIDTH{1'bz}};

    // ptr names the next free slot, so the top entry sits one below it.
    assign ret_addr = stack[ptr - PW'(1)];

    always_comb begin
        addr_next  = i_addr;
        ptr_next   = ptr;
        count_next = count;
        ovf_next   = rs_ovf;
        unf_next   = rs_unf;
        if (call) begin
            addr_next = d_bus;
            ptr_next  = ptr + PW'(1);
            if (count == FULL) ovf_next = 1'b1;
            else               count_next = count + CW'(1);
        end else if (ret) begin
            if (count == '0) begin
                unf_next = 1'b1;
            end else begin
                addr_next  = ret_addr;
                ptr_next   = ptr - PW'(1);
                count_next = count - CW'(1);
            end
        end else if (load) begin
            addr_next = d_bus;
        end else if (branch) begin
            addr_next = i_addr + d_bus;
        end else if (increment) begin
            addr_next = i_addr + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr   <= RESET_VEC;
            ptr      <= '0;
            count    <= '0;
            rs_empty <= 1'b1;
            rs_full  <= 1'b0;
            rs_ovf   <= 1'b0;
            rs_unf   <= 1'b0;
        end else begin
            i_addr   <= addr_next;
            ptr      <= ptr_next;
            count    <= count_next;
            rs_empty <= (count_next == '0);
            rs_full  <= (count_next == FULL);
            rs_ovf   <= ovf_next;
            rs_unf   <= unf_next;
        end
    end

    // Storage survives reset; a full stack simply overwrites its oldest slot.
    always_ff @(posedge clk) begin
        if (!rst && call) stack[ptr] <= i_addr + WIDTH'(1);
    end
endmodule

// File: tb/tb_program_counter_rs.sv
// Directed literal checks plus randomized traffic against a queue-based PC/RAS model.
module tb_program_counter_rs;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0, increment = 1'b0, load = 1'b0, branch = 1'b0;
    logic        call = 1'b0, ret = 1'b0, push = 1'b0, push_d = 1'b0;
    logic [15:0] tb_bus = '0;
    wire  [15:0] d_bus, d_addr, i_addr;
    wire         rs_empty, rs_full, rs_ovf, rs_unf;

    assign d_bus = push_d ? 16'bz : tb_bus;

    program_counter_rs #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'd16)) dut (
        .clk(clk), .rst(rst), .increment(increment), .load(load), .branch(branch),
        .call(call), .ret(ret), .push(push), .push_d(push_d), .d_bus(d_bus),
        .d_addr(d_addr), .i_addr(i_addr), .rs_empty(rs_empty), .rs_full(rs_full),
        .rs_ovf(rs_ovf), .rs_unf(rs_unf));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fetch address plus a bounded LIFO of return addresses.
    logic [15:0] m_addr = 16'd16;
    logic [15:0] m_stack[$];
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    always @(posedge clk) begin
        assert (!(push_d && (load || branch || call)))
            else $error("protocol violation: push_d with a bus-sampling command");
        if (rst) begin
            m_addr = 16'd16; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (call) begin
            m_stack.push_back(m_addr + 16'd1);
            if (m_stack.size() > DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_addr = tb_bus;
        end else if (ret) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else m_addr = m_stack.pop_back();
        end else if (load)      m_addr = tb_bus;
        else if (branch)        m_addr = m_addr + tb_bus;
        else if (increment)     m_addr = m_addr + 16'd1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("i_addr", i_addr, m_addr);
            chk("rs_empty", rs_empty, m_stack.size() == 0);
            chk("rs_full", rs_full, m_stack.size() == DEPTH);
            chk("rs_ovf", rs_ovf, m_ovf);
            chk("rs_unf", rs_unf, m_unf);
            if (push) chk("d_addr driven", d_addr, m_addr);
            else if (m_addr != 16'd0)
                chk("d_addr released", (d_addr === 16'bz || d_addr === 16'd0), 1'b1);
            if (push_d) chk("d_bus driven", d_bus, m_addr);
            else        chk("d_bus released", d_bus, tb_bus);
        end
    end

    // Inputs change 1 time unit after a falling edge and hold across one rising edge.
    task automatic cyc(input logic r, inc, ld, br, cl, rt, ps, pd, input logic [15:0] bus);
        #1;
        rst = r; increment = inc; load = ld; branch = br; call = cl; ret = rt;
        push = ps; push_d = pd; tb_bus = bus;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // 1: reset then increments
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        chk_en = 1'b1;
        chk("reset i_addr", i_addr, 16'd16);
        chk("reset flags", {rs_empty, rs_full, rs_ovf, rs_unf}, 4'b1000);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
            chk("inc seq", i_addr, 16'd16 + 16'(k));
        end
        chk("inc empty", rs_empty, 1'b1);
        // 2: call / ret pair
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 16'h0010);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 16'h0200);
        chk("call target", i_addr, 16'h0200);
        chk("call nonempty", rs_empty, 1'b0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        chk("ret addr", i_addr, 16'h0011);
        chk("ret empty", rs_empty, 1'b1);
        // 3: nine nested calls, overflow, LIFO unwinding, underflow
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 16'h1000 + 16'(k));
            if (k == 7) chk("full no ovf", {rs_full, rs_ovf}, 2'b10);
        end
        chk("ovf after 9", {rs_full, rs_ovf}, 2'b11);
        for (int k = 8; k >= 1; k--) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
            chk("lifo ret", i_addr, 16'h1000 + 16'(k));
        end
        chk("unwound empty", {rs_empty, rs_unf}, 2'b10);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        chk("unf hold", i_addr, 16'h1001);
        chk("unf set", rs_unf, 1'b1);
        // 4: negative branch, wrap
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 16'h0005);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFE);
        chk("branch back", i_addr, 16'h0003);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 16'hFFFF);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        chk("inc wrap", i_addr, 16'h0000);
        // 5: priority, reset during ret
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 16'h0040);
        cyc(0, 1, 0, 0, 1, 1, 0, 0, 16'h0300);
        chk("call wins", i_addr, 16'h0300);
        chk("call wins cnt", rs_empty, 1'b0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        chk("rst in ret", i_addr, 16'd16);
        chk("rst flags", {rs_empty, rs_full, rs_ovf, rs_unf}, 4'b1000);
        // 6: tri-state drivers
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        chk("d_addr on", d_addr, 16'd16);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 16'h0);
        chk("d_bus on", d_bus, 16'd17);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'hA5A5);
        chk("d_bus off", d_bus, 16'hA5A5);

        // Random traffic weighted toward stack activity and bus boundary values.
        for (int n = 0; n < 3000; n++) begin
            logic r, inc, ld, br, cl, rt, ps, pd;
            logic [15:0] bus;
            r   = ($urandom_range(0, 79) == 0);
            cl  = ($urandom_range(0, 99) < 28);
            rt  = ($urandom_range(0, 99) < 30);
            ld  = ($urandom_range(0, 99) < 10);
            br  = ($urandom_range(0, 99) < 10);
            inc = ($urandom_range(0, 99) < 50);
            ps  = 1'($urandom);
            pd  = 1'($urandom) && !(ld || br || cl);
            case ($urandom_range(0, 7))
                0: bus = 16'hFFFF;
                1: bus = 16'h0000;
                2: bus = 16'h8000;
                default: bus = 16'($urandom);
            endcase
            cyc(r, inc, ld, br, cl, rt, ps, pd, bus);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
